// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC load/hold/squash for start, halt and table-indexed branches.
// Optional call/return stack is enabled by defining FETCH_SEQ_CALL_STACK_EN.
module fetch_sequencer #(
    parameter int PC_W        = 9,
    parameter int LUT_DEPTH   = 32,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
`ifdef FETCH_SEQ_CALL_STACK_EN
    input  logic            call_en,
    input  logic            ret_en,
    input  logic [PC_W-1:0] pc,
    output logic            stack_err,
`endif
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic            branch_en,
    input  logic            branch_cond,
    input  logic [4:0]      lut_idx,
    input  logic            done_req,
    input  logic            lut_wr_en,
    input  logic [4:0]      lut_wr_idx,
    input  logic [PC_W-1:0] lut_wr_data,
    output logic            pc_write,
    output logic [PC_W-1:0] jump_target,
    output logic            pc_hold,
    output logic            squash,
    output logic            running,
    output logic            done,
    output logic [15:0]     run_cycles,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cyc_q, cyc_d;
    logic            start_acc;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];
    logic [PC_W-1:0] lut_rd;

    // Target table: the read below sees the pre-write contents in the write cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_wr_en && (int'(lut_wr_idx) < LUT_DEPTH)) begin
            lut_q[lut_wr_idx] <= lut_wr_data;
        end
    end

    always_comb begin
        lut_rd = '0;
        if (int'(lut_idx) < LUT_DEPTH) begin
            lut_rd = lut_q[lut_idx];
        end
    end

`ifdef FETCH_SEQ_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0] sp_q, sp_m1;
    logic            err_q;
    logic            push, pop, err_set;
    logic            stack_full, stack_empty;
    logic [PC_W-1:0] stack_top;

    assign sp_m1       = sp_q - 1'b1;
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign stack_top   = stack_q[sp_m1[IDX_W-1:0]];
    assign stack_err   = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            if (push) begin
                stack_q[sp_q[IDX_W-1:0]] <= pc + PC_W'(1);
                sp_q                     <= sp_q + 1'b1;
            end else if (pop) begin
                sp_q <= sp_m1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        jump_target = '0;
        pc_hold     = 1'b1;
        squash      = 1'b0;
        start_acc   = 1'b0;
`ifdef FETCH_SEQ_CALL_STACK_EN
        push        = 1'b0;
        pop         = 1'b0;
        err_set     = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc   = 1'b1;
                    pc_write    = 1'b1;
                    jump_target = start_addr;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                pc_hold = 1'b0;
                // Halt outranks branch, which outranks ret, which outranks call.
                if (done_req) begin
                    pc_hold = 1'b1;
                    state_d = S_DONE;
                end else if (branch_en) begin
                    if (branch_cond) begin
                        pc_write    = 1'b1;
                        jump_target = lut_rd;
                        state_d     = S_FLUSH;
                    end
                end
`ifdef FETCH_SEQ_CALL_STACK_EN
                else if (ret_en) begin
                    if (stack_empty) begin
                        err_set = 1'b1;
                    end else begin
                        pop         = 1'b1;
                        pc_write    = 1'b1;
                        jump_target = stack_top;
                        state_d     = S_FLUSH;
                    end
                end else if (call_en) begin
                    if (stack_full) begin
                        err_set = 1'b1;
                    end else begin
                        push        = 1'b1;
                        pc_write    = 1'b1;
                        jump_target = lut_rd;
                        state_d     = S_FLUSH;
                    end
                end
`endif
            end
            S_FLUSH: begin
                pc_hold = 1'b0;
                squash  = 1'b1;
                state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        // A start pulse seen while reset is held must not leak onto the PC load.
        if (reset) begin
            pc_write    = 1'b0;
            jump_target = '0;
            pc_hold     = 1'b1;
            squash      = 1'b0;
        end
    end

    always_comb begin
        cyc_d = cyc_q;
        if (start_acc) begin
            cyc_d = '0;
        end else if (running && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    assign running     = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done        = (state_q == S_DONE);
    assign run_cycles  = cyc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, multi-cycle corner sequences and
// randomized traffic scored against a behavioural model of the sequencing rules.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  start_addr;
    logic        branch_en;
    logic        branch_cond;
    logic [4:0]  lut_idx;
    logic        done_req;
    logic        lut_wr_en;
    logic [4:0]  lut_wr_idx;
    logic [8:0]  lut_wr_data;
    logic        pc_write;
    logic [8:0]  jump_target;
    logic        pc_hold;
    logic        squash;
    logic        running;
    logic        done;
    logic [15:0] run_cycles;
    logic [1:0]  dbg_state;
    logic        call_en;
    logic        ret_en;
    logic [8:0]  pc;
`ifdef FETCH_SEQ_CALL_STACK_EN
    logic        stack_err;
`endif

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.PC_W(9), .LUT_DEPTH(32), .STACK_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef FETCH_SEQ_CALL_STACK_EN
        .call_en     (call_en),
        .ret_en      (ret_en),
        .pc          (pc),
        .stack_err   (stack_err),
`endif
        .start       (start),
        .start_addr  (start_addr),
        .branch_en   (branch_en),
        .branch_cond (branch_cond),
        .lut_idx     (lut_idx),
        .done_req    (done_req),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data),
        .pc_write    (pc_write),
        .jump_target (jump_target),
        .pc_hold     (pc_hold),
        .squash      (squash),
        .running     (running),
        .done        (done),
        .run_cycles  (run_cycles),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        start       = 1'b0;
        start_addr  = '0;
        branch_en   = 1'b0;
        branch_cond = 1'b0;
        lut_idx     = '0;
        done_req    = 1'b0;
        lut_wr_en   = 1'b0;
        lut_wr_idx  = '0;
        lut_wr_data = '0;
        call_en     = 1'b0;
        ret_en      = 1'b0;
        pc          = '0;
    endtask

    // Behavioural model: "executing" covers RUN and FLUSH, "flush_due" marks the
    // single squash cycle after a taken jump, "halted" marks a completed program.
    logic [8:0]  m_lut [32];
    logic [8:0]  m_stack [$];
    bit          m_exec, m_flush_due, m_halted, m_err;
    int unsigned m_cycles;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_lut[i] = '0;
        m_stack.delete();
        m_exec      = 0;
        m_flush_due = 0;
        m_halted    = 0;
        m_err       = 0;
        m_cycles    = 0;
    endtask

    task automatic model_predict(output logic pw, output logic [8:0] jt,
                                 output logic ph, output logic sq);
        pw = 1'b0; jt = '0; ph = 1'b1; sq = 1'b0;
        if (!m_exec) begin
            if (start) begin pw = 1'b1; jt = start_addr; end
        end else if (m_flush_due) begin
            ph = 1'b0; sq = 1'b1;
        end else if (!done_req) begin
            ph = 1'b0;
            if (branch_en) begin
                if (branch_cond) begin pw = 1'b1; jt = m_lut[lut_idx]; end
            end
`ifdef FETCH_SEQ_CALL_STACK_EN
            else if (ret_en) begin
                if (m_stack.size() > 0) begin pw = 1'b1; jt = m_stack[$]; end
            end else if (call_en) begin
                if (m_stack.size() < 4) begin pw = 1'b1; jt = m_lut[lut_idx]; end
            end
`endif
        end
    endtask

    task automatic model_advance();
        logic [8:0] ret_pc;
        ret_pc = pc + 9'd1;
        if (m_exec) m_cycles++;
        if (!m_exec) begin
            if (start) begin m_exec = 1; m_halted = 0; m_cycles = 0; end
        end else if (m_flush_due) begin
            m_flush_due = 0;
        end else if (done_req) begin
            m_exec = 0; m_halted = 1;
        end else if (branch_en) begin
            m_flush_due = branch_cond;
        end
`ifdef FETCH_SEQ_CALL_STACK_EN
        else if (ret_en) begin
            if (m_stack.size() > 0) begin void'(m_stack.pop_back()); m_flush_due = 1; end
            else m_err = 1;
        end else if (call_en) begin
            if (m_stack.size() < 4) begin m_stack.push_back(ret_pc); m_flush_due = 1; end
            else m_err = 1;
        end
`endif
        if (lut_wr_en) m_lut[lut_wr_idx] = lut_wr_data;
    endtask

    // Scoreboard compare at the current (quiet) time point.
    task automatic model_cmp();
        logic       e_pw, e_ph, e_sq;
        logic [8:0] e_jt;
        model_predict(e_pw, e_jt, e_ph, e_sq);
        chk("m_pc_write", pc_write, e_pw);
        chk("m_jump_target", jump_target, e_jt);
        chk("m_pc_hold", pc_hold, e_ph);
        chk("m_squash", squash, e_sq);
        chk("m_running", running, m_exec);
        chk("m_done", done, m_halted);
        chk("m_run_cycles", run_cycles, (m_cycles > 65535) ? 65535 : m_cycles);
`ifdef FETCH_SEQ_CALL_STACK_EN
        chk("m_stack_err", stack_err, m_err);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic cyc_model();
        @(negedge clk);
        model_cmp();
        tick();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    typedef struct {
        logic        st;  logic [8:0] sa;
        logic        be;  logic       bc;  logic [4:0] idx; logic dr;
        logic        we;  logic [4:0] wi;  logic [8:0] wd;
        logic        pw;  logic [8:0] jt;  logic ph; logic sq; logic rn; logic dn;
        logic [15:0] cyc;
    } vec_t;

    function automatic vec_t mk(logic st, logic [8:0] sa, logic be, logic bc, logic [4:0] idx,
                                logic dr, logic we, logic [4:0] wi, logic [8:0] wd,
                                logic pw, logic [8:0] jt, logic ph, logic sq, logic rn,
                                logic dn, logic [15:0] cyc);
        vec_t v;
        v.st = st; v.sa = sa; v.be = be; v.bc = bc; v.idx = idx; v.dr = dr;
        v.we = we; v.wi = wi; v.wd = wd; v.pw = pw; v.jt = jt; v.ph = ph;
        v.sq = sq; v.rn = rn; v.dn = dn; v.cyc = cyc;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        //            st  sa      be bc idx dr we wi wd      pw jt      ph sq rn dn cyc
        vecs[0]  = mk(1, 9'h010, 0, 0, 0, 0, 1, 3, 9'h1A0, 1, 9'h010, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 9'h000, 0, 0, 0, 0, 1, 5, 9'h055, 0, 9'h000, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 9'h000, 1, 1, 3, 0, 0, 0, 9'h000, 1, 9'h1A0, 0, 0, 1, 0, 1);
        vecs[3]  = mk(1, 9'h111, 1, 1, 3, 0, 0, 0, 9'h000, 0, 9'h000, 0, 1, 1, 0, 2);
        vecs[4]  = mk(1, 9'h111, 0, 0, 0, 0, 0, 0, 9'h000, 0, 9'h000, 0, 0, 1, 0, 3);
        vecs[5]  = mk(0, 9'h000, 1, 1, 5, 0, 1, 5, 9'h0AB, 1, 9'h055, 0, 0, 1, 0, 4);
        vecs[6]  = mk(0, 9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 9'h000, 0, 1, 1, 0, 5);
        vecs[7]  = mk(0, 9'h000, 1, 1, 5, 0, 0, 0, 9'h000, 1, 9'h0AB, 0, 0, 1, 0, 6);
        vecs[8]  = mk(0, 9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 9'h000, 0, 1, 1, 0, 7);
        vecs[9]  = mk(0, 9'h000, 1, 0, 5, 0, 0, 0, 9'h000, 0, 9'h000, 0, 0, 1, 0, 8);
        vecs[10] = mk(0, 9'h000, 1, 1, 3, 1, 0, 0, 9'h000, 0, 9'h000, 1, 0, 1, 0, 9);
        vecs[11] = mk(0, 9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 9'h000, 1, 0, 0, 1, 10);
        vecs[12] = mk(0, 9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 9'h000, 1, 0, 0, 1, 10);
        vecs[13] = mk(1, 9'h1F0, 0, 0, 0, 0, 0, 0, 9'h000, 1, 9'h1F0, 1, 0, 0, 1, 10);
        vecs[14] = mk(0, 9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 9'h000, 0, 0, 1, 0, 0);

        // Reset state, with a start pulse held to show it cannot leak through.
        drive_idle();
        reset      = 1'b1;
        start      = 1'b1;
        start_addr = 9'h010;
        #3;
        chk("rst_pc_write", pc_write, 0);
        chk("rst_jump_target", jump_target, 0);
        chk("rst_pc_hold", pc_hold, 1);
        chk("rst_squash", squash, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_run_cycles", run_cycles, 0);
`ifdef FETCH_SEQ_CALL_STACK_EN
        chk("rst_stack_err", stack_err, 0);
`endif
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            start       = vecs[i].st;
            start_addr  = vecs[i].sa;
            branch_en   = vecs[i].be;
            branch_cond = vecs[i].bc;
            lut_idx     = vecs[i].idx;
            done_req    = vecs[i].dr;
            lut_wr_en   = vecs[i].we;
            lut_wr_idx  = vecs[i].wi;
            lut_wr_data = vecs[i].wd;
            @(negedge clk);
            chk($sformatf("vec%0d_pc_write", i), pc_write, vecs[i].pw);
            chk($sformatf("vec%0d_jump_target", i), jump_target, vecs[i].jt);
            chk($sformatf("vec%0d_pc_hold", i), pc_hold, vecs[i].ph);
            chk($sformatf("vec%0d_squash", i), squash, vecs[i].sq);
            chk($sformatf("vec%0d_running", i), running, vecs[i].rn);
            chk($sformatf("vec%0d_done", i), done, vecs[i].dn);
            chk($sformatf("vec%0d_run_cycles", i), run_cycles, vecs[i].cyc);
            tick();
        end
        drive_idle();

        // Reset during FLUSH: no squash, back to idle, table cleared.
        branch_en = 1'b1; branch_cond = 1'b1; lut_idx = 5'd3;
        cyc_model();
        drive_idle();
        chk("flush_entered", squash, 1);
        reset      = 1'b1;
        start      = 1'b1;
        start_addr = 9'h0AA;
        #1;
        chk("rstflush_squash", squash, 0);
        chk("rstflush_running", running, 0);
        chk("rstflush_done", done, 0);
        chk("rstflush_pc_hold", pc_hold, 1);
        chk("rstflush_pc_write", pc_write, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; start_addr = 9'h020;
        cyc_model();
        drive_idle();
        branch_en = 1'b1; branch_cond = 1'b1; lut_idx = 5'd3;
        @(negedge clk);
        model_cmp();
        chk("lut3_cleared", jump_target, 9'h000);
        chk("lut3_pc_write", pc_write, 1);
        tick();
        drive_idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            start       = ($urandom_range(0, 7) == 0);
            start_addr  = 9'($urandom_range(0, 511));
            done_req    = ($urandom_range(0, 19) == 0);
            branch_en   = ($urandom_range(0, 2) == 0);
            branch_cond = $urandom_range(0, 1) == 1;
            lut_idx     = 5'($urandom_range(0, 31));
            lut_wr_en   = ($urandom_range(0, 3) == 0);
            lut_wr_idx  = 5'($urandom_range(0, 31));
            lut_wr_data = 9'($urandom_range(0, 511));
`ifdef FETCH_SEQ_CALL_STACK_EN
            call_en     = ($urandom_range(0, 4) == 0);
            ret_en      = ($urandom_range(0, 5) == 0);
            pc          = 9'($urandom_range(0, 511));
`endif
            cyc_model();
        end
        drive_idle();

`ifdef FETCH_SEQ_CALL_STACK_EN
        // Call stack: return address wraps, fifth call overflows.
        apply_reset();
        start = 1'b1; lut_wr_en = 1'b1; lut_wr_idx = 5'd2; lut_wr_data = 9'h0C0;
        cyc_model();
        drive_idle();
        for (int k = 0; k < 4; k++) begin
            call_en = 1'b1; pc = 9'h1FF; lut_idx = 5'd2;
            @(negedge clk);
            model_cmp();
            chk("call_pc_write", pc_write, 1);
            chk("call_jump_target", jump_target, 9'h0C0);
            tick();
            drive_idle();
            cyc_model();
        end
        call_en = 1'b1; pc = 9'h1FF; lut_idx = 5'd2;
        @(negedge clk);
        model_cmp();
        chk("call_full_pc_write", pc_write, 0);
        tick();
        drive_idle();
        @(negedge clk);
        model_cmp();
        chk("call_full_stack_err", stack_err, 1);
        chk("call_full_no_squash", squash, 0);
        chk("call_full_running", running, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            ret_en = 1'b1;
            @(negedge clk);
            model_cmp();
            chk("ret_pc_write", pc_write, 1);
            chk("ret_target_wrapped", jump_target, 9'h000);
            tick();
            drive_idle();
            cyc_model();
        end
`endif

        // Cycle counter saturation.
        apply_reset();
        start = 1'b1;
        cyc_model();
        drive_idle();
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("sat_run_cycles", run_cycles, 16'hFFFF);
        chk("sat_running", running, 1);
        @(negedge clk);
        chk("sat_hold", run_cycles, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
